bp_train_unit: RTL and testbench

//  Receiving end of the execute->memory branch-training fields. Accepts one training packet per

---
 rtl/bp_train_unit_if.sv | 43 ++++
 rtl/bp_train_unit.sv | 201 ++++++++++++++++++++
 tb/tb_bp_train_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/bp_train_unit_if.sv
// Branch-training and fetch-lookup bundle for bp_train_unit.
// slave = predictor side, master = pipeline/fetch side.
interface bp_train_unit_if #(
  parameter int PC_WIDTH = 32,
  parameter int HIST_W   = 8
);
  logic                train_vaild_i;
  logic [PC_WIDTH-1:0] train_pc_i;
  logic [HIST_W-1:0]   train_hist_i;
  logic                train_taken_i;
  logic                train_global_pred_i;
  logic                train_local_pred_i;
  logic                train_full_o;
  logic [PC_WIDTH-1:0] lookup_pc_i;
  logic [HIST_W-1:0]   lookup_hist_i;
  logic                lookup_taken_o;
  logic                lookup_use_global_o;
  logic [7:0]          drop_cnt_o;
  logic [31:0]         mispred_cnt_o;
  logic [31:0]         update_cnt_o;

  modport master (
    output train_vaild_i, train_pc_i,
    output train_hist_i, train_taken_i,
    output train_global_pred_i,
    output train_local_pred_i,
    output lookup_pc_i, lookup_hist_i,
    input  train_full_o, lookup_taken_o,
    input  lookup_use_global_o, drop_cnt_o,
    input  mispred_cnt_o, update_cnt_o
  );

  modport slave (
    input  train_vaild_i, train_pc_i,
    input  train_hist_i, train_taken_i,
    input  train_global_pred_i,
    input  train_local_pred_i,
    input  lookup_pc_i, lookup_hist_i,
    output train_full_o, lookup_taken_o,
    output lookup_use_global_o, drop_cnt_o,
    output mispred_cnt_o, update_cnt_o
  );
endinterface

// File: rtl/bp_train_unit.sv
// Tournament predictor trainer: packet FIFO, 2-cycle RMW of GPHT/LPHT/CHO.
// Optional update/mispredict counters under BP_TRAIN_STATS_EN.
module bp_train_unit #(
  parameter int PC_WIDTH   = 32,
  parameter int HIST_W     = 8,
  parameter int IDX_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk_i,
  input logic           rst,
  bp_train_unit_if.slave bus
);
  localparam int TBL = 1 << IDX_W;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int HW  = (HIST_W < IDX_W) ? HIST_W : IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] lidx;
    logic [IDX_W-1:0] gidx;
    logic             taken;
    logic             gp;
    logic             lp;
  } pkt_t;

  function automatic logic [IDX_W-1:0] hfold(
    input logic [HIST_W-1:0] h
  );
    return IDX_W'(h[HW-1:0]);
  endfunction

  function automatic logic [1:0] sat(
    input logic [1:0] c,
    input logic       up
  );
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic [1:0] r_gpht [TBL];
  logic [1:0] r_lpht [TBL];
  logic [1:0] r_cho  [TBL];

  pkt_t          r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_full;
  logic [7:0]    r_drop;

  state_t r_state;
  state_t w_state_nxt;
  pkt_t   r_h;
  logic [1:0] r_g;
  logic [1:0] r_l;
  logic [1:0] r_c;

  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [CW-1:0] w_cnt_nxt;
  pkt_t          w_in;
  pkt_t          w_head;
  logic          w_unused;

  logic [IDX_W-1:0] w_lk_lidx;
  logic [IDX_W-1:0] w_lk_gidx;

  assign w_unused = ^{bus.train_pc_i,
                      bus.lookup_pc_i,
                      bus.train_hist_i,
                      bus.lookup_hist_i};

  always_comb begin
    w_in       = '0;
    w_in.lidx  = bus.train_pc_i[IDX_W+1:2];
    w_in.gidx  = w_in.lidx ^ hfold(bus.train_hist_i);
    w_in.taken = bus.train_taken_i;
    w_in.gp    = bus.train_global_pred_i;
    w_in.lp    = bus.train_local_pred_i;
  end

  // A WRITE frees a slot on the same edge, so a full FIFO still accepts.
  assign w_pop  = (r_state == S_WRITE);
  assign w_push = bus.train_vaild_i &
                  (~r_full | w_pop);
  assign w_drop = bus.train_vaild_i &
                  r_full & ~w_pop;
  assign w_cnt_nxt = r_cnt + CW'(w_push)
                   - CW'(w_pop);
  assign w_head = r_fifo[r_rp];

  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
      r_drop <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wp] <= w_in;
        r_wp         <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt  <= w_cnt_nxt;
      r_full <= (w_cnt_nxt == CW'(FIFO_DEPTH));
      if (w_drop && r_drop != 8'hFF)
        r_drop <= r_drop + 8'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (r_cnt != '0) w_state_nxt = S_READ;
      S_READ:
        w_state_nxt = S_WRITE;
      S_WRITE:
        w_state_nxt = (w_cnt_nxt != '0) ?
                      S_READ : S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (r_state == S_READ) begin
      r_h <= w_head;
      r_g <= r_gpht[w_head.gidx];
      r_l <= r_lpht[w_head.lidx];
      r_c <= r_cho[w_head.lidx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      for (int i = 0; i < TBL; i++) begin
        r_gpht[i] <= 2'b01;
        r_lpht[i] <= 2'b01;
        r_cho[i]  <= 2'b10;
      end
    end else if (r_state == S_WRITE) begin
      r_gpht[r_h.gidx] <= sat(r_g, r_h.taken);
      r_lpht[r_h.lidx] <= sat(r_l, r_h.taken);
      // Chooser learns only when the components disagree.
      if (r_h.gp != r_h.lp)
        r_cho[r_h.lidx] <=
          sat(r_c, r_h.gp == r_h.taken);
    end
  end

  assign w_lk_lidx = bus.lookup_pc_i[IDX_W+1:2];
  assign w_lk_gidx = w_lk_lidx ^
                     hfold(bus.lookup_hist_i);

  assign bus.lookup_use_global_o =
    r_cho[w_lk_lidx][1];
  assign bus.lookup_taken_o =
    r_cho[w_lk_lidx][1] ? r_gpht[w_lk_gidx][1]
                        : r_lpht[w_lk_lidx][1];
  assign bus.train_full_o = r_full;
  assign bus.drop_cnt_o   = r_drop;

`ifdef BP_TRAIN_STATS_EN
  logic [31:0] r_upd;
  logic [31:0] r_misp;
  logic        w_fpred;

  assign w_fpred = r_c[1] ? r_h.gp : r_h.lp;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_upd  <= '0;
      r_misp <= '0;
    end else if (r_state == S_WRITE) begin
      r_upd <= r_upd + 32'd1;
      if (w_fpred != r_h.taken)
        r_misp <= r_misp + 32'd1;
    end
  end

  assign bus.update_cnt_o  = r_upd;
  assign bus.mispred_cnt_o = r_misp;
`else
  assign bus.update_cnt_o  = '0;
  assign bus.mispred_cnt_o = '0;
`endif
endmodule

// File: tb/tb_bp_train_unit.sv
// Scoreboard bench for bp_train_unit: expected lookups queued
// with stimulus, compared after the trainer drains.
module tb_bp_train_unit;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bp_train_unit_if #(
    .PC_WIDTH(32),
    .HIST_W(8)
  ) bus ();

  bp_train_unit #(
    .PC_WIDTH(32),
    .HIST_W(8),
    .IDX_W(8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [7:0]  hist;
    logic        ug;
    logic        tk;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [31:0] pc,
    input logic [7:0]  h,
    input logic        t,
    input logic        g,
    input logic        l
  );
    bus.train_vaild_i       = 1'b1;
    bus.train_pc_i          = pc;
    bus.train_hist_i        = h;
    bus.train_taken_i       = t;
    bus.train_global_pred_i = g;
    bus.train_local_pred_i  = l;
    tick();
  endtask

  task automatic idle(input int n);
    bus.train_vaild_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic expect_lk(
    input string       tag,
    input logic [31:0] pc,
    input logic [7:0]  h,
    input logic        ug,
    input logic        tk
  );
    exp_t e;
    e.tag  = tag;
    e.pc   = pc;
    e.hist = h;
    e.ug   = ug;
    e.tk   = tk;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.lookup_pc_i   = e.pc;
      bus.lookup_hist_i = e.hist;
      @(negedge clk);
      chk({e.tag, ".use_global"},
          32'(bus.lookup_use_global_o), 32'(e.ug));
      chk({e.tag, ".taken"},
          32'(bus.lookup_taken_o), 32'(e.tk));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                     = 1'b1;
    bus.train_vaild_i       = 1'b0;
    bus.train_pc_i          = '0;
    bus.train_hist_i        = '0;
    bus.train_taken_i       = 1'b0;
    bus.train_global_pred_i = 1'b0;
    bus.train_local_pred_i  = 1'b0;
    bus.lookup_pc_i         = '0;
    bus.lookup_hist_i       = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst.full", 32'(bus.train_full_o), 0);
    chk("rst.drop", 32'(bus.drop_cnt_o), 0);
    chk("rst.upd", bus.update_cnt_o, 0);
    chk("rst.misp", bus.mispred_cnt_o, 0);
    expect_lk("rst.lk", 32'h100, 8'h00, 1'b1, 1'b0);
    drain();

    // Latency: push at E0, visible only after E3.
    send(32'h100, 8'h00, 1'b1, 1'b0, 1'b0);
    bus.train_vaild_i = 1'b0;
    bus.lookup_pc_i   = 32'h100;
    bus.lookup_hist_i = 8'h00;
    tick();
    chk("lat.e1", 32'(bus.lookup_taken_o), 0);
    tick();
    chk("lat.e2", 32'(bus.lookup_taken_o), 0);
    tick();
    chk("lat.e3", 32'(bus.lookup_taken_o), 1);
    chk("lat.ug", 32'(bus.lookup_use_global_o), 1);

    // Chooser walks 10->01->00; LPHT[0x80] ends at 11.
    send(32'h200, 8'h00, 1'b1, 1'b0, 1'b1);
    send(32'h200, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(12);
    expect_lk("cho", 32'h200, 8'h01, 1'b0, 1'b1);
    drain();

    // History hash: gidx 0x18^0x03 = 0x1B.
    send(32'h60, 8'h03, 1'b1, 1'b1, 1'b1);
    idle(8);
    expect_lk("hash.h3", 32'h60, 8'h03, 1'b1, 1'b1);
    expect_lk("hash.h0", 32'h60, 8'h00, 1'b1, 1'b0);
    drain();

    // Burst of 7: pops land on E3 and E5, full after
    // E4, so only the E6 packet finds no free slot.
    for (int i = 0; i < 7; i++) begin
      send(32'h300 + 32'(4 * i), 8'h00,
           1'b1, 1'b1, 1'b1);
      if (i == 4)
        chk("burst.full", 32'(bus.train_full_o), 1);
      expect_lk($sformatf("burst%0d", i),
                32'h300 + 32'(4 * i), 8'h00,
                1'b1, i < 6);
    end
    idle(20);
    chk("burst.drop", 32'(bus.drop_cnt_o), 1);
    chk("burst.empty", 32'(bus.train_full_o), 0);
    drain();

    // Saturation at idx 0x10.
    repeat (4) send(32'h40, 8'h00, 1'b1, 1'b1, 1'b1);
    idle(12);
    expect_lk("sat.hi", 32'h40, 8'h00, 1'b1, 1'b1);
    drain();
    send(32'h40, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(6);
    expect_lk("sat.hi-1", 32'h40, 8'h00, 1'b1, 1'b1);
    drain();
    repeat (4) send(32'h40, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(12);
    expect_lk("sat.lo", 32'h40, 8'h00, 1'b1, 1'b0);
    drain();
    send(32'h40, 8'h00, 1'b1, 1'b1, 1'b1);
    idle(6);
    expect_lk("sat.lo+1", 32'h40, 8'h00, 1'b1, 1'b0);
    drain();
    send(32'h40, 8'h00, 1'b1, 1'b1, 1'b1);
    idle(6);
    expect_lk("sat.lo+2", 32'h40, 8'h00, 1'b1, 1'b1);
    drain();

    // Reset lands on the WRITE edge (E3).
    send(32'h80, 8'h00, 1'b1, 1'b1, 1'b1);
    bus.train_vaild_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(6);
    chk("rstw.full", 32'(bus.train_full_o), 0);
    chk("rstw.drop", 32'(bus.drop_cnt_o), 0);
    chk("rstw.upd", bus.update_cnt_o, 0);
    chk("rstw.misp", bus.mispred_cnt_o, 0);
    expect_lk("rstw.x80", 32'h80, 8'h00, 1'b1, 1'b0);
    expect_lk("rstw.x100", 32'h100, 8'h00, 1'b1, 1'b0);
    expect_lk("rstw.x200", 32'h200, 8'h00, 1'b1, 1'b0);
    expect_lk("rstw.x300", 32'h300, 8'h00, 1'b1, 1'b0);
    drain();

    // Three updates, the last one mispredicted.
    send(32'hC0, 8'h00, 1'b1, 1'b1, 1'b1);
    send(32'hC0, 8'h00, 1'b0, 1'b0, 1'b0);
    send(32'hC0, 8'h00, 1'b0, 1'b1, 1'b1);
    idle(12);
`ifdef BP_TRAIN_STATS_EN
    chk("stats.upd", bus.update_cnt_o, 3);
    chk("stats.misp", bus.mispred_cnt_o, 1);
`else
    chk("stats.upd", bus.update_cnt_o, 0);
    chk("stats.misp", bus.mispred_cnt_o, 0);
`endif
    expect_lk("stats.lk", 32'hC0, 8'h00, 1'b1, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
